// File: rtl/lfo_pkg.sv
// lfo_pkg: shared types and constants for the LFO sequencer slice.
//   lfoState_t      : controller state (IDLE, RUN, DRAIN)
//   FREQ_*          : LFOgen frequency codes
//   SCALE_W/FREQ_W  : LFOgen depth and frequency code widths
//   WAVE_W          : width of LFOgen's signed wave output
package lfo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lfoState_t;

    localparam int SCALE_W = 4;
    localparam int FREQ_W  = 4;
    localparam int WAVE_W  = 16;

    localparam logic [FREQ_W-1:0] FREQ_1HZ = 4'd3;
    localparam logic [FREQ_W-1:0] FREQ_4HZ = 4'd13;

endpackage

// File: rtl/lfo_tick_div.sv
// lfo_tick_div: sample-rate divider. While en is high the counter runs
// 0..CYCLES-1 and wraps; strobe is a registered one-cycle pulse that follows
// the terminal count. While en is low the counter is held at 0, no strobes.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   en     : run enable
//   strobe : one-cycle pulse every CYCLES clocks, first one CYCLES clocks after en rises
module lfo_tick_div #(
    parameter int CYCLES = 136
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic strobe
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            strobe <= 1'b0;
        end else if (!en) begin
            count  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= (count == LAST);
            count  <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lfo_ctrl.sv
// lfo_ctrl: sequencer and configuration front-end for LFOgen.
//   clk_i          : 6 MHz system clock
//   rst_n_i        : asynchronous reset, ACTIVE HIGH despite the name (matches LFOgen)
//   en_i           : effect enable
//   cfgValid_i/cfgReady_o, freqReq_i, scaleReq_i : one-slot config handshake
//   lfoWave_i, lfoNewVal_i : LFOgen sample and its valid flag
//   fifoUpdate_o   : per-sample strobe to LFOgen
//   freqSetting_o, scaleFactor_o : LFOgen frequency code and (ramped) depth
//   delayOffset_o, delayValid_o  : saturated delay-line read offset and its update pulse
//   busy_o         : controller not idle
//   lfoTimeout_o   : sticky flag, LFOgen failed to answer a strobe in time
//
// state | meaning
// IDLE  | divider stopped, config applied immediately, LFO answers ignored
// RUN   | strobing, depth ramps toward the requested target
// DRAIN | strobing, depth ramps toward 0; leaves to IDLE on a tick at depth 0
module lfo_ctrl
    import lfo_pkg::*;
#(
    parameter int TICK_CYCLES    = 136,
    parameter int RAMP_TICKS     = 4,
    parameter int DELAY_W        = 11,
    parameter int CENTER         = 1024,
    parameter int WAVE_SHIFT     = 6,
    parameter int TIMEOUT_CYCLES = 8,
    parameter logic [FREQ_W-1:0] FREQ_DEFAULT = FREQ_1HZ
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic                     cfgValid_i,
    output logic                     cfgReady_o,
    input  logic [FREQ_W-1:0]        freqReq_i,
    input  logic [SCALE_W-1:0]       scaleReq_i,
    input  logic signed [WAVE_W-1:0] lfoWave_i,
    input  logic                     lfoNewVal_i,
    output logic                     fifoUpdate_o,
    output logic [FREQ_W-1:0]        freqSetting_o,
    output logic [SCALE_W-1:0]       scaleFactor_o,
    output logic [DELAY_W-1:0]       delayOffset_o,
    output logic                     delayValid_o,
    output logic                     busy_o,
    output logic                     lfoTimeout_o
);

    localparam int SUM_W  = 18;
    localparam int RAMP_W = $clog2(RAMP_TICKS + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
    // Loaded on the edge after the strobe; counting down to 0 and then one
    // more silent cycle makes the flag rise TIMEOUT_CYCLES clocks after the strobe.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'((1 << DELAY_W) - 1);

    lfoState_t          state;
    logic               active;
    logic [FREQ_W-1:0]  pendFreq;
    logic [SCALE_W-1:0] pendScale;
    logic [SCALE_W-1:0] scaleTarget;
    logic [SCALE_W-1:0] effTarget;
    logic [RAMP_W-1:0]  rampCnt;
    logic [WD_W-1:0]    wdCnt;
    logic               wdArmed;

    logic signed [SUM_W-1:0] waveExt;
    logic signed [SUM_W-1:0] waveShifted;
    logic signed [SUM_W-1:0] delaySum;
    logic [DELAY_W-1:0]      delaySat;

    assign active = (state != IDLE);

    lfo_tick_div #(
        .CYCLES (TICK_CYCLES)
    ) uTickDiv (
        .clk    (clk_i),
        .rst    (rst_n_i),
        .en     (active),
        .strobe (fifoUpdate_o)
    );

    always_comb begin
        effTarget   = (state == DRAIN) ? '0 : scaleTarget;
        waveExt     = {{(SUM_W - WAVE_W){lfoWave_i[WAVE_W-1]}}, lfoWave_i};
        waveShifted = waveExt >>> WAVE_SHIFT;
        delaySum    = waveShifted + CENTER_S;
        if (delaySum < 0)
            delaySat = '0;
        else if (delaySum > MAX_S)
            delaySat = '1;
        else
            delaySat = delaySum[DELAY_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            cfgReady_o    <= 1'b1;
            pendFreq      <= '0;
            pendScale     <= '0;
            freqSetting_o <= FREQ_DEFAULT;
            scaleTarget   <= '0;
            scaleFactor_o <= '0;
            rampCnt       <= '0;
            delayOffset_o <= DELAY_W'(CENTER);
            delayValid_o  <= 1'b0;
            wdCnt         <= '0;
            wdArmed       <= 1'b0;
            lfoTimeout_o  <= 1'b0;
        end else begin
            delayValid_o <= 1'b0;

            // Config slot: accept when empty; apply at once in IDLE, otherwise
            // on the edge that ends a strobe cycle so LFOgen keeps the old code
            // for that sample. A request landing on a strobe edge waits a period.
            if (cfgValid_i && cfgReady_o) begin
                pendFreq   <= freqReq_i;
                pendScale  <= scaleReq_i;
                cfgReady_o <= 1'b0;
            end else if (!cfgReady_o && (!active || fifoUpdate_o)) begin
                freqSetting_o <= pendFreq;
                scaleTarget   <= pendScale;
                cfgReady_o    <= 1'b1;
            end

            // Ramp counter idles at 0 while on target, so a new target always
            // takes its first step RAMP_TICKS ticks after it is applied.
            if (fifoUpdate_o) begin
                if (scaleFactor_o == effTarget) begin
                    rampCnt <= '0;
                end else if (rampCnt == RAMP_LAST) begin
                    rampCnt <= '0;
                    if (scaleFactor_o < effTarget)
                        scaleFactor_o <= scaleFactor_o + SCALE_W'(1);
                    else
                        scaleFactor_o <= scaleFactor_o - SCALE_W'(1);
                end else begin
                    rampCnt <= rampCnt + RAMP_W'(1);
                end
            end

            if (active && lfoNewVal_i) begin
                delayOffset_o <= delaySat;
                delayValid_o  <= 1'b1;
            end

            if (!active) begin
                wdArmed <= 1'b0;
            end else if (fifoUpdate_o) begin
                wdArmed <= 1'b1;
                wdCnt   <= WD_LOAD;
            end else if (wdArmed) begin
                if (lfoNewVal_i) begin
                    wdArmed <= 1'b0;
                end else if (wdCnt == '0) begin
                    lfoTimeout_o <= 1'b1;
                    wdArmed      <= 1'b0;
                end else begin
                    wdCnt <= wdCnt - WD_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (en_i) begin
                        state        <= RUN;
                        busy_o       <= 1'b1;
                        lfoTimeout_o <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en_i)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (en_i) begin
                        state <= RUN;
                    end else if (fifoUpdate_o && scaleFactor_o == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfo_ctrl.sv
module tb_lfo_ctrl;

    logic               clk;
    logic               rst;
    logic               en;
    logic               cfgValid;
    logic [3:0]         freqReq;
    logic [3:0]         scaleReq;
    logic signed [15:0] lfoWave;
    logic               lfoNewVal;

    logic        cfgReady, fifoUpdate, delayValid, busy, lfoTimeout;
    logic [3:0]  freqSetting, scaleFactor;
    logic [10:0] delayOffset;
    logic        d2CfgReady, d2FifoUpdate, d2DelayValid, d2Busy, d2LfoTimeout;
    logic [3:0]  d2FreqSetting, d2ScaleFactor;
    logic [10:0] d2DelayOffset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic               stubOn;
    logic signed [15:0] stubWave;

    lfo_ctrl dut (
        .clk_i(clk), .rst_n_i(rst), .en_i(en),
        .cfgValid_i(cfgValid), .cfgReady_o(cfgReady),
        .freqReq_i(freqReq), .scaleReq_i(scaleReq),
        .lfoWave_i(lfoWave), .lfoNewVal_i(lfoNewVal),
        .fifoUpdate_o(fifoUpdate), .freqSetting_o(freqSetting),
        .scaleFactor_o(scaleFactor), .delayOffset_o(delayOffset),
        .delayValid_o(delayValid), .busy_o(busy), .lfoTimeout_o(lfoTimeout)
    );

    lfo_ctrl #(.CENTER(2040)) dut2 (
        .clk_i(clk), .rst_n_i(rst), .en_i(en),
        .cfgValid_i(cfgValid), .cfgReady_o(d2CfgReady),
        .freqReq_i(freqReq), .scaleReq_i(scaleReq),
        .lfoWave_i(lfoWave), .lfoNewVal_i(lfoNewVal),
        .fifoUpdate_o(d2FifoUpdate), .freqSetting_o(d2FreqSetting),
        .scaleFactor_o(d2ScaleFactor), .delayOffset_o(d2DelayOffset),
        .delayValid_o(d2DelayValid), .busy_o(d2Busy), .lfoTimeout_o(d2LfoTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end, cycles %0d", cyc);
        $fatal(1);
    end

    // LFOgen stand-in: answers each strobe two clocks later with stubWave.
    initial begin
        lfoNewVal = 1'b0;
        lfoWave   = '0;
        forever begin
            @(posedge clk); #1;
            if (fifoUpdate && stubOn && !rst) begin
                @(posedge clk);
                @(posedge clk); #1;
                lfoWave   = stubWave;
                lfoNewVal = 1'b1;
                @(posedge clk); #1;
                lfoNewVal = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic waitStrobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (fifoUpdate) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL strobe_timeout: no fifoUpdate within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    typedef struct {
        logic signed [15:0] wave;
        int                 exp1;
        int                 exp2;
    } mapVec_t;

    mapVec_t vecs[9];

    initial begin
        bit ok;
        int startCyc, lastS, bad, lat, quiet;

        vecs[0] = '{16'sh8000,       512, 1528};
        vecs[1] = '{16'sd0,         1024, 2040};
        vecs[2] = '{16'sd32767,     1535, 2047};
        vecs[3] = '{-16'sd1,        1023, 2039};
        vecs[4] = '{16'sd63,        1024, 2040};
        vecs[5] = '{16'sd64,        1025, 2041};
        vecs[6] = '{16'sd448,       1031, 2047};
        vecs[7] = '{16'sd447,       1030, 2046};
        vecs[8] = '{-16'sd32704,     513, 1529};

        rst = 1'b1; en = 1'b0; cfgValid = 1'b0; freqReq = '0; scaleReq = '0;
        stubOn = 1'b1; stubWave = '0;
        step(); step();

        check("rst_cfgReady", cfgReady, 1);
        check("rst_freq", freqSetting, 3);
        check("rst_scale", scaleFactor, 0);
        check("rst_fifo", fifoUpdate, 0);
        check("rst_offset", delayOffset, 1024);
        check("rst_offset_c2040", d2DelayOffset, 2040);
        check("rst_valid", delayValid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", lfoTimeout, 0);

        rst = 1'b0;
        step();

        // Config in IDLE: applied the cycle after the transfer.
        freqReq = 4'd3; scaleReq = 4'd15; cfgValid = 1'b1;
        step();
        cfgValid = 1'b0;
        check("idle_cfg_ready_drop", cfgReady, 0);
        step();
        check("idle_cfg_ready_back", cfgReady, 1);
        check("idle_scale_not_jump", scaleFactor, 0);

        // Tick period and ramp-up.
        en = 1'b1;
        step();
        check("busy_run", busy, 1);
        startCyc = cyc;
        lastS    = cyc;
        for (int t = 1; t <= 64; t++) begin
            waitStrobe(ok);
            if (t == 1) check("first_strobe", cyc - startCyc, 136);
            else if (t <= 5) check("strobe_period", cyc - lastS, 136);
            lastS = cyc;
            step();
            if (t <= 5) check("strobe_width", fifoUpdate, 0);
            if (t == 3)  check("ramp_t3", scaleFactor, 0);
            if (t == 4)  check("ramp_t4", scaleFactor, 1);
            if (t == 59) check("ramp_t59", scaleFactor, 14);
            if (t == 60) check("ramp_t60", scaleFactor, 15);
            if (t == 64) check("ramp_hold15", scaleFactor, 15);
        end

        // Descend to 8: applied at the next strobe, then 7 steps of 4 ticks.
        freqReq = 4'd3; scaleReq = 4'd8; cfgValid = 1'b1;
        step();
        cfgValid = 1'b0;
        waitStrobe(ok);
        step();
        check("desc_apply_edge", scaleFactor, 15);
        for (int t = 1; t <= 32; t++) begin
            waitStrobe(ok);
            step();
            if (t == 4)  check("desc_t4", scaleFactor, 14);
            if (t == 24) check("desc_t24", scaleFactor, 9);
            if (t == 28) check("desc_t28", scaleFactor, 8);
            if (t == 32) check("desc_hold8", scaleFactor, 8);
        end

        // Mid-period request held valid while pending; request lines change meanwhile.
        repeat (50) step();
        freqReq = 4'd13; scaleReq = 4'd15; cfgValid = 1'b1;
        step();
        check("run_cfg_ready_drop", cfgReady, 0);
        freqReq = 4'd7; scaleReq = 4'd1;
        bad = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (fifoUpdate) begin
                ok = 1'b1;
                break;
            end
            if (cfgReady !== 1'b0) bad++;
        end
        check("cfg_pending_strobe_seen", ok, 1);
        check("cfg_ready_held_low", bad, 0);
        check("freq_old_at_strobe", freqSetting, 3);
        cfgValid = 1'b0;
        step();
        check("freq_new_after_strobe", freqSetting, 13);
        check("cfg_ready_after_apply", cfgReady, 1);

        // Delay mapping table, both centre settings.
        foreach (vecs[i]) begin
            stubWave = vecs[i].wave;
            waitStrobe(ok);
            lat = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                lat++;
                if (delayValid) break;
            end
            check($sformatf("map_latency_%0d", i), lat, 3);
            check($sformatf("map_c1024_%0d", i), delayOffset, vecs[i].exp1);
            check($sformatf("map_c2040_%0d", i), d2DelayOffset, vecs[i].exp2);
            step();
            check($sformatf("map_valid_width_%0d", i), delayValid, 0);
        end
        check("freq_kept", freqSetting, 13);

        // Watchdog.
        check("wd_clear_before", lfoTimeout, 0);
        stubOn = 1'b0;
        waitStrobe(ok);
        repeat (7) step();
        check("wd_not_early", lfoTimeout, 0);
        step();
        check("wd_fire", lfoTimeout, 1);
        stubOn = 1'b1;
        waitStrobe(ok);
        repeat (4) step();
        check("wd_sticky", lfoTimeout, 1);

        // Finish ramp back up to 15 (new target from the 13/15 request).
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (scaleFactor == 4'd15) begin
                ok = 1'b1;
                break;
            end
            waitStrobe(ok);
            step();
        end
        check("reach15_again", scaleFactor, 15);

        // Drain: 60 ticks to 0, IDLE on the next tick.
        en = 1'b0;
        step();
        check("drain_busy", busy, 1);
        for (int t = 1; t <= 61; t++) begin
            waitStrobe(ok);
            step();
            if (t == 59) check("drain_t59", scaleFactor, 1);
            if (t == 60) begin
                check("drain_t60", scaleFactor, 0);
                check("drain_t60_busy", busy, 1);
            end
            if (t == 61) check("drain_idle_busy", busy, 0);
        end
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (fifoUpdate) quiet++;
        end
        check("idle_no_strobes", quiet, 0);
        check("wd_sticky_idle", lfoTimeout, 1);

        en = 1'b1;
        step();
        check("wd_cleared_on_run", lfoTimeout, 0);
        check("busy_rerun", busy, 1);
        for (int t = 1; t <= 28; t++) begin
            waitStrobe(ok);
            step();
        end
        check("ramp_mid7", scaleFactor, 7);

        // Async reset mid-ramp with a pending request.
        repeat (20) step();
        freqReq = 4'd5; cfgValid = 1'b1;
        step();
        cfgValid = 1'b0;
        check("pend_before_reset", cfgReady, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_scale", scaleFactor, 0);
        check("arst_freq", freqSetting, 3);
        check("arst_cfgReady", cfgReady, 1);
        check("arst_busy", busy, 0);
        check("arst_offset", delayOffset, 1024);
        check("arst_offset_c2040", d2DelayOffset, 2040);
        check("arst_fifo", fifoUpdate, 0);
        check("arst_valid", delayValid, 0);
        en = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        check("no_pending_after_reset", freqSetting, 3);
        check("ready_after_reset", cfgReady, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfo_ctrl.md
Name: lfo_ctrl

Overview:
Sequencer and configuration front-end for LFOgen in the modulated-delay (chorus/vibrato) path.
- Generates the per-sample FIFOupdate strobe from the 6 MHz system clock.
- Applies user frequency/depth requests only at sample boundaries, and ramps depth to avoid zipper noise.
- Supervises LFOgen's newValFlag response.
- Converts each LFO sample into an unsigned delay-line read offset for the delay buffer.

Parameters:
TICK_CYCLES, 136, system clocks per audio sample (6 MHz / 44.1 kHz)
RAMP_TICKS, 4, sample ticks per one-step change of scaleFactor_o
DELAY_W, 11, width of delay offset output
CENTER, 1024, nominal delay offset (samples) at wave = 0
WAVE_SHIFT, 6, arithmetic right shift applied to wave before adding CENTER
TIMEOUT_CYCLES, 8, max clocks from strobe to lfoNewVal_i
FREQ_DEFAULT, 3, freqSetting_o value after reset

Ports:
clk_i  in  1  system clock, 6 MHz
rst_n_i  in  1  asynchronous, active-high reset (same name and polarity as LFOgen)
en_i  in  1  effect enable
cfgValid_i  in  1  config request valid
cfgReady_o  out  1  config slot free
freqReq_i  in  4  requested LFO frequency code
scaleReq_i  in  4  requested depth (target scale)
lfoWave_i  in  16  signed LFOgen wave_o
lfoNewVal_i  in  1  LFOgen newValFlag_o
fifoUpdate_o  out  1  one-cycle sample strobe to LFOgen FIFOupdate_i
freqSetting_o  out  4  to LFOgen freqSetting_i
scaleFactor_o  out  4  to LFOgen scaleFactor_i
delayOffset_o  out  DELAY_W  delay-line read offset
delayValid_o  out  1  one-cycle pulse, delayOffset_o updated
busy_o  out  1  state != IDLE
lfoTimeout_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, active-high): state IDLE, tick counter 0, ramp counter 0, pending slot empty. Outputs: cfgReady_o=1, freqSetting_o=FREQ_DEFAULT, scaleFactor_o=0, fifoUpdate_o=0, delayOffset_o=CENTER, delayValid_o=0, busy_o=0, lfoTimeout_o=0. Internal scale target resets to 0.
- Reset asserted mid-operation (mid-ramp, mid-watchdog, config pending) returns to these values immediately; no pending config survives.
- States:
  - IDLE: tick counter held at 0; no strobes; lfoNewVal_i ignored. en_i=1 -> RUN, and lfoTimeout_o clears.
  - RUN: ramps toward the scale target. en_i=0 -> DRAIN.
  - DRAIN: ramps toward 0. en_i=1 -> RUN. On a tick with scaleFactor_o==0 -> IDLE.
- Tick: in RUN/DRAIN the counter runs 0..TICK_CYCLES-1 and wraps. fifoUpdate_o is registered, high exactly one cycle when the counter == TICK_CYCLES-1. The first strobe occurs TICK_CYCLES cycles after entering RUN.
- Config handshake: transfer when cfgValid_i && cfgReady_o. Data is stored in the pending slot and cfgReady_o drops the next cycle.
  - In IDLE, pending data is applied the following cycle.
  - In RUN/DRAIN, pending data is applied on the clock edge that ends the strobe cycle. LFOgen therefore sees the old freq on that strobe and the new one from the next strobe.
  - After apply, the slot empties and cfgReady_o=1.
  - A transfer in the same cycle as a strobe is applied at the next strobe, not the current one.
- Apply: freqSetting_o <= freqReq; scale target <= scaleReq.
- Ramp: ramp counter increments per tick. When it reaches RAMP_TICKS, it resets and scaleFactor_o moves ±1 toward the target (target = 0 in DRAIN). No overshoot; holds at target.
- Delay mapping: on lfoNewVal_i in RUN/DRAIN, compute CENTER + (lfoWave_i >>> WAVE_SHIFT) in signed 18-bit.
  - Saturate to [0, 2^DELAY_W-1].
  - Register result; delayValid_o pulses the cycle after lfoNewVal_i (latency 1).
- Watchdog: starts at each strobe. If TIMEOUT_CYCLES clocks elapse without lfoNewVal_i, set lfoTimeout_o (sticky until reset or IDLE->RUN). A new strobe restarts the watchdog.

Decomposition:
- Package lfo_pkg: state enum (IDLE, RUN, DRAIN), freq code constants (e.g. FREQ_1HZ=3, FREQ_4HZ=13), SCALE_W=4, WAVE_W=16.
- One sub-module, lfo_tick_div: parameterised counter with enable, producing the registered one-cycle strobe.
- Mapping, ramp, handshake and FSM stay in lfo_ctrl.

Test Plan:
- Tick period: en_i=1 for 5 strobes -> fifoUpdate_o one cycle wide, strobes exactly 136 clocks apart, first at 136 clocks after RUN entry.
- Ramp: scaleReq=15 accepted in IDLE, then en_i=1 -> scaleFactor_o steps 0->1 at tick 4 and reaches 15 at tick 60, never exceeding 15. Change to scaleReq=8 -> descends 15->8 in 28 ticks.
- Config timing: freqReq=13 accepted mid-period in RUN -> freqSetting_o stays 3 through the next strobe and becomes 13 the following cycle; cfgValid_i held during pending -> cfgReady_o=0, no second transfer.
- Mapping (stub LFO answers 2 clocks after strobe): wave -32768 -> 512; 0 -> 1024; 32767 -> 1535; each with delayValid_o one cycle later. With CENTER=2040, wave 32767 -> 2047 (saturated).
- Watchdog: stub never asserts lfoNewVal_i -> lfoTimeout_o=1 at strobe+8. It stays set; en_i 0->drain->IDLE->en_i=1 clears it.
- Drain/reset: en_i=0 at scale 15 -> 60 ticks down to 0, then IDLE, busy_o=0, no further strobes. Reset asserted at scale 7 mid-ramp -> all outputs at reset values immediately, without waiting for a clock edge.
